// File: rtl/conv2d_window_pkg.sv
// Shared types for the streaming 3x3 window generator: pixel/window typedefs,
// the frame-sequencing state enum and the border-padding helper.
package conv2d_window_pkg;

    localparam int FILT_DIM  = 3;
    localparam int PIXEL_W   = 16;
    localparam int TAP_FIRST = 0;
    localparam int TAP_LAST  = FILT_DIM - 1;

    typedef logic signed [PIXEL_W-1:0] pixel_t;
    typedef pixel_t [FILT_DIM-1:0][FILT_DIM-1:0] window_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } win_state_t;

    // A tap is padding when it falls on a window edge that lies outside the image.
    function automatic logic tap_is_pad(
        input logic top_edge,
        input logic bottom_edge,
        input logic left_edge,
        input logic right_edge,
        input int   row_idx,
        input int   col_idx
    );
        return (top_edge    && (row_idx == TAP_FIRST)) ||
               (bottom_edge && (row_idx == TAP_LAST))  ||
               (left_edge   && (col_idx == TAP_FIRST)) ||
               (right_edge  && (col_idx == TAP_LAST));
    endfunction

endpackage

// File: rtl/conv2d_window_gen_line_buffer_row.sv
// One image row of delay: a DEPTH-entry circular buffer that returns the value
// written DEPTH advances ago and overwrites it with the incoming one.
module line_buffer_row
    import conv2d_window_pkg::*;
#(
    parameter int DEPTH = 28
)(
    input  logic   clock,
    input  logic   reset,
    input  logic   advance,
    input  pixel_t wr_data,
    output pixel_t rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    pixel_t          mem_r [DEPTH];
    logic [AW-1:0]   ptr_r;

    assign rd_data = mem_r[ptr_r];

    // Ring pointer, one step per advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (advance) begin
            if (ptr_r == PTR_LAST) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= ptr_r + 1'b1;
            end
        end
    end

    // Storage is deliberately not cleared; stale contents only reach padded taps.
    always_ff @(posedge clock) begin
        if (advance) begin
            mem_r[ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/conv2d_window_gen.sv
// Streaming "same"-padded 3x3 window generator feeding the conv2D sum stage.
// Optional CONV2D_WINDOW_COORD_EN adds out_row/out_col center-coordinate outputs.
module conv2d_window_gen
    import conv2d_window_pkg::*;
#(
    parameter int filtDimension = 3,
    parameter int bitWidth      = 16,
    parameter int imgWidth      = 28,
    parameter int imgHeight     = 28
)(
    input  logic    clock,
    input  logic    reset,
    input  logic    in_valid,
    output logic    in_ready,
    input  pixel_t  in_data,
    output logic    out_valid,
    input  logic    out_ready,
    output window_t zeroedMatrix
`ifdef CONV2D_WINDOW_COORD_EN
    ,
    output logic [$clog2(imgHeight)-1:0] out_row,
    output logic [$clog2(imgWidth)-1:0]  out_col
`endif
);

    localparam int CW = $clog2(imgWidth);
    localparam int RW = $clog2(imgHeight);
    localparam logic [CW-1:0] COL_LAST = CW'(imgWidth - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(imgHeight - 1);

    if (filtDimension != FILT_DIM) begin : g_bad_filt
        $error("conv2d_window_gen: only filtDimension == 3 is supported");
    end
    if (bitWidth != PIXEL_W) begin : g_bad_width
        $error("conv2d_window_gen: bitWidth must match conv2d_window_pkg::PIXEL_W");
    end
    if ((imgWidth < 2) || (imgHeight < 2)) begin : g_bad_dims
        $error("conv2d_window_gen: imgWidth and imgHeight must both be >= 2");
    end

    win_state_t    state_r;
    win_state_t    next_state_s;
    logic [CW-1:0] in_col_r;
    logic [RW-1:0] in_row_r;
    logic [CW-1:0] ctr_col_r;
    logic [RW-1:0] ctr_row_r;
    logic          in_ready_s;
    logic          accept_s;
    logic          load_s;
    logic          advance_s;
    logic          out_valid_r;
    pixel_t        new_pix_s;
    pixel_t        lb1_rd_s;
    pixel_t        lb2_rd_s;
    window_t       taps_r;
    window_t       taps_next_s;
    window_t       masked_s;
    window_t       win_r;

    assign in_ready     = in_ready_s & ~reset;
    assign accept_s     = in_valid & in_ready_s & ~reset;
    assign advance_s    = accept_s | ((state_r == FLUSH) & load_s);
    assign new_pix_s    = (state_r == FLUSH) ? pixel_t'(16'sd0) : in_data;
    assign out_valid    = out_valid_r;
    assign zeroedMatrix = win_r;

    // Frame sequencing: decides when inputs are taken and when a window loads.
    always_comb begin
        next_state_s = state_r;
        in_ready_s   = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            FILL: begin
                in_ready_s = 1'b1;
                if (in_valid && (in_row_r == RW'(1)) && (in_col_r == CW'(0))) begin
                    next_state_s = STREAM;
                end else begin
                    next_state_s = FILL;
                end
            end
            STREAM: begin
                in_ready_s = ~out_valid_r | out_ready;
                load_s     = in_valid & in_ready_s;
                if (load_s && (in_row_r == ROW_LAST) && (in_col_r == COL_LAST)) begin
                    next_state_s = FLUSH;
                end else begin
                    next_state_s = STREAM;
                end
            end
            FLUSH: begin
                load_s = ~out_valid_r | out_ready;
                if (load_s && (ctr_row_r == ROW_LAST) && (ctr_col_r == COL_LAST)) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = FLUSH;
                end
            end
            default: begin
                next_state_s = FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FILL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_col_r <= '0;
            in_row_r <= '0;
        end else if (accept_s) begin
            if (in_col_r == COL_LAST) begin
                in_col_r <= '0;
                in_row_r <= (in_row_r == ROW_LAST) ? '0 : in_row_r + 1'b1;
            end else begin
                in_col_r <= in_col_r + 1'b1;
            end
        end
    end

    // Center coordinate of the next window to load; also drives the padding mask.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctr_col_r <= '0;
            ctr_row_r <= '0;
        end else if (load_s) begin
            if (ctr_col_r == COL_LAST) begin
                ctr_col_r <= '0;
                ctr_row_r <= (ctr_row_r == ROW_LAST) ? '0 : ctr_row_r + 1'b1;
            end else begin
                ctr_col_r <= ctr_col_r + 1'b1;
            end
        end
    end

    line_buffer_row #(.DEPTH(imgWidth)) u_lb_near (
        .clock   (clock),
        .reset   (reset),
        .advance (advance_s),
        .wr_data (new_pix_s),
        .rd_data (lb1_rd_s)
    );

    line_buffer_row #(.DEPTH(imgWidth)) u_lb_far (
        .clock   (clock),
        .reset   (reset),
        .advance (advance_s),
        .wr_data (lb1_rd_s),
        .rd_data (lb2_rd_s)
    );

    // Shift taps left; the new right column is {two rows up, one row up, current}.
    always_comb begin
        taps_next_s = taps_r;
        for (int i = 0; i < FILT_DIM; i++) begin
            for (int j = 0; j < FILT_DIM - 1; j++) begin
                taps_next_s[i][j] = taps_r[i][j+1];
            end
        end
        taps_next_s[0][TAP_LAST] = lb2_rd_s;
        taps_next_s[1][TAP_LAST] = lb1_rd_s;
        taps_next_s[2][TAP_LAST] = new_pix_s;
    end

    // Zero every tap whose position lies outside the image for this center.
    always_comb begin
        masked_s = taps_next_s;
        for (int i = 0; i < FILT_DIM; i++) begin
            for (int j = 0; j < FILT_DIM; j++) begin
                if (tap_is_pad(ctr_row_r == RW'(0), ctr_row_r == ROW_LAST,
                               ctr_col_r == CW'(0), ctr_col_r == COL_LAST, i, j)) begin
                    masked_s[i][j] = pixel_t'(16'sd0);
                end else begin
                    masked_s[i][j] = taps_next_s[i][j];
                end
            end
        end
    end

    // Tap shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            taps_r <= '0;
        end else if (advance_s) begin
            taps_r <= taps_next_s;
        end
    end

    // Output window register: loads on a slot, holds under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            win_r       <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            win_r       <= masked_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef CONV2D_WINDOW_COORD_EN
    logic [RW-1:0] out_row_r;
    logic [CW-1:0] out_col_r;

    assign out_row = out_row_r;
    assign out_col = out_col_r;

    // Center coordinate registered alongside the window it describes.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_row_r <= '0;
            out_col_r <= '0;
        end else if (load_s) begin
            out_row_r <= ctr_row_r;
            out_col_r <= ctr_col_r;
        end
    end
`endif

endmodule

// File: doc/conv2d_window_gen.md
# conv2d_window_gen

Streaming 3x3 window generator that produces the zero-padded `zeroedMatrix` consumed by the conv2D sum/weight stage. Accepts one raster-order pixel per handshake, buffers two image rows, and emits one centered 3x3 window per input pixel ("same" convolution). Out-of-image taps are forced to zero. It sits between the activation stream (input image or previous layer) and the convolution multiply-accumulate stage.

## Interface
- `filtDimension`, 3: window size; only 3 is supported, elaboration error otherwise.
- `bitWidth`, 16: signed pixel width (fixed-point, NFRAC irrelevant here).
- `imgWidth`, 28: pixels per row, W ≥ 2.
- `imgHeight`, 28: rows per frame, H ≥ 2.

Ports:
- `clock`  in  1  sole clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts pixel this cycle.
- `in_data`  in  bitWidth signed  pixel, raster order, row 0 col 0 first.
- `out_valid`  out  1  `zeroedMatrix` holds a window.
- `out_ready`  in  1  downstream takes window this cycle.
- `zeroedMatrix`  out  bitWidth signed [3][3]  window; [i][j] = pixel(rc−1+i, cc−1+j), 0 if outside image; [0][*] is the top row.

## Operation
- Pixel accepted when `in_valid && in_ready`; window transferred when `out_valid && out_ready`.
- Pixel index p = r·W + c, counted by internal row/col counters that wrap at W and H.
- Window with center index q = p − (W+1) becomes available when pixel p is accepted.
- States:
  - FILL: pixels 0..W accepted, no windows. `in_ready` = 1. Goes to STREAM after accepting p = W.
  - STREAM: each accepted pixel loads one window into the output register. `in_ready` = `!out_valid || out_ready`. Goes to FLUSH after accepting p = H·W−1.
  - FLUSH: `in_ready` = 0. Emits the remaining W+1 windows (centers H·W−W−1 … H·W−1) with bottom/right taps zeroed, one per free output slot. Goes to FILL after the last window loads.
- Line buffers are never cleared between frames; padding is applied solely from center coordinates.
- Data path is pass-through: no arithmetic, no width change; sign is preserved.

## Timing
- Reset: `out_valid` = 0, `zeroedMatrix` all 0, counters 0, state FILL, and `in_ready` = 0 while `reset` is high.
- Output register latency is 1 cycle: the window for q appears the cycle after pixel q+W+1 is accepted.
- Frame latency: the first `out_valid` occurs the cycle after the (W+2)-th accepted pixel.
- Backpressure:
  - `zeroedMatrix` and `out_valid` hold stable while `out_valid && !out_ready`.
  - A simultaneous output transfer and input accept in STREAM loads the next window with no bubble.
- Throughput is 1 window/cycle with continuous `in_valid` and `out_ready`. A frame ends with W+1 FLUSH cycles during which no input is accepted.
- Reset mid-frame: the partial frame is discarded, the next accepted pixel is (0,0), and no stale window is emitted.

## Configuration
- `CONV2D_WINDOW_COORD_EN` defined:
  - Adds outputs `out_row` and `out_col`, each `$clog2(imgHeight)` and `$clog2(imgWidth)` bits wide, giving the center coordinate of the current window.
  - Both reset to 0 and follow the same hold rule as `zeroedMatrix`.
- Undefined: ports and tracking logic are absent. Window behaviour is identical.

## Structure
- Package `conv2d_window_pkg`:
  - `FILT_DIM` = 3.
  - `pixel_t` (signed bitWidth).
  - `win_state_t` enum {FILL, STREAM, FLUSH}.
  - Window typedef `pixel_t [FILT_DIM-1:0][FILT_DIM-1:0]`.
- Sub-module `line_buffer_row`: W-deep circular buffer, one write/read per accept. Instantiated twice in a cascade. A 3x3 tap shift register plus border mask lives in the top level.

## Test plan
- 4x4 frame with values 1..16, always ready:
  - First window (center 0,0) = [[0,0,0],[0,1,2],[0,5,6]].
  - Window (1,1) = [[1,2,3],[5,6,7],[9,10,11]].
  - Last window (3,3) = [[11,12,0],[15,16,0],[0,0,0]].
  - Exactly 16 windows are emitted.
- Same frame with `out_ready` low for 3 cycles at window 5: window 5 holds unchanged, `in_ready` = 0 during the stall, and there is no loss or duplication.
- Two back-to-back frames (second = 17..32): second frame's window (0,0) = [[0,0,0],[0,17,18],[0,21,22]], with no leakage of frame-1 data.
- Negative pixels (−1 = all ones): sign bits are preserved in every tap, and padded taps are exactly 0.
- Assert `reset` after 7 pixels, then send a fresh 4x4 frame: `out_valid` = 0 the cycle after reset, and the first window matches the first scenario.
- With `CONV2D_WINDOW_COORD_EN`: `out_row`/`out_col` step (0,0),(0,1)…(3,3) in lockstep with the windows.
